// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit holding HI/LO: fixed-latency multiply/accumulate and
// radix-2 restoring divide. Define MDU_DIV0_FAST_EN to finish divide-by-zero in one cycle.
module mdu_iter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       mdu_op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH + MUL_LAT + 2);
    localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_INIT = CW'(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e r_state, w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo, r_quo, r_rem, r_dvs;
    logic             r_done;

    logic             w_accept, w_is_mul, w_is_div, w_write, w_sgn, w_a_neg, w_b_neg, w_ge;
    logic [CW-1:0]    w_div_init;
    logic [2*WIDTH-1:0] w_ma, w_mb, w_prod, w_acc, w_mul_res, w_result;
    logic [WIDTH-1:0] w_a_abs, w_b_abs, w_sub, w_q_fix, w_r_fix;
    logic [WIDTH:0]   w_shift;

    assign w_is_mul = (mdu_op == 4'd1) || (mdu_op == 4'd2) ||
                      (mdu_op >= 4'd5 && mdu_op <= 4'd8);
    assign w_is_div = (mdu_op == 4'd3) || (mdu_op == 4'd4);
    assign w_accept = start && !cancel && (r_state == StIdle);

`ifdef MDU_DIV0_FAST_EN
    assign w_div_init = (in2 == '0) ? '0 : DIV_INIT;
`else
    assign w_div_init = DIV_INIT;
`endif

    // Multiply: sign/zero-extend to 2*WIDTH so the truncated product is exact mod 2^(2W).
    assign w_sgn     = (r_op == 4'd1) || (r_op == 4'd3) || (r_op == 4'd5) || (r_op == 4'd7);
    assign w_a_neg   = w_sgn && r_a[WIDTH-1];
    assign w_b_neg   = w_sgn && r_b[WIDTH-1];
    assign w_ma      = {{WIDTH{w_a_neg}}, r_a};
    assign w_mb      = {{WIDTH{w_b_neg}}, r_b};
    assign w_prod    = w_ma * w_mb;
    assign w_acc     = {r_hi, r_lo};

    always_comb begin
        w_mul_res = w_prod;
        if (r_op == 4'd5 || r_op == 4'd6) begin
            w_mul_res = w_acc + w_prod;
        end else if (r_op == 4'd7 || r_op == 4'd8) begin
            w_mul_res = w_acc - w_prod;
        end
    end

    // Divide: operate on magnitudes, fix signs on the final write.
    assign w_a_abs = w_a_neg ? -r_a : r_a;
    assign w_b_abs = w_b_neg ? -r_b : r_b;
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = w_shift >= {1'b0, r_dvs};
    // The true difference is below 2^WIDTH whenever it is taken, so low-bit math is exact.
    assign w_sub   = w_shift[WIDTH-1:0] - r_dvs;
    assign w_q_fix = (w_a_neg ^ w_b_neg) ? -r_quo : r_quo;
    assign w_r_fix = w_a_neg ? -r_rem : r_rem;

    always_comb begin
        w_result = w_mul_res;
        if (r_state == StDiv) begin
            if (r_b == '0) begin
                w_result = {r_a, {WIDTH{1'b1}}};
            end else begin
                w_result = {w_r_fix, w_q_fix};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept && w_is_mul) begin
                    w_state_next = StMul;
                end else if (w_accept && w_is_div) begin
                    w_state_next = StDiv;
                end
            end
            StMul, StDiv: begin
                if (cancel || r_cnt == '0) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        busy    = (r_state != StIdle);
        stall   = busy || (start && mdu_op >= 4'd1 && mdu_op <= 4'd8);
        w_write = busy && !cancel && (r_cnt == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_write;
            if (w_accept) begin
                r_op <= mdu_op;
                r_a  <= in1;
                r_b  <= in2;
                if (w_is_mul) r_cnt <= MUL_INIT;
                if (w_is_div) r_cnt <= w_div_init;
                if (mdu_op == 4'd9)  r_hi <= in1;
                if (mdu_op == 4'd10) r_lo <= in1;
            end else if (busy) begin
                if (cancel) begin
                    r_cnt <= '0;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_state == StDiv && r_cnt == DIV_INIT) begin
                        r_quo <= w_a_abs;
                        r_rem <= '0;
                        r_dvs <= w_b_abs;
                    end else if (r_state == StDiv) begin
                        r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    end
                end
            end
            if (w_write) begin
                {r_hi, r_lo} <= w_result;
            end
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule
